// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data-memory responder for the MEM stage.
// Serves one load/store at a time after LATENCY wait states, with valid/ready on both sides.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | ready for a request; req_ready=1
  // WAIT  | counting wait states; access happens on the edge where cnt==0
  // RESP  | response held stable until rsp_ready
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign in_range = (addr_q[31:ADDR_W] == '0);
  assign idx      = addr_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT_CNT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          if (in_range) begin
            err_d = 1'b0;
            if (we_q) begin
              mem_we  = 1'b1;
              rdata_d = '0;
            end else begin
              rdata_d = mem[idx];
            end
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; a reset in WAIT clears state_q so mem_we never fires.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: randomized and directed traffic against a
// word-level memory model, plus latency measurement on LATENCY=0 and LATENCY=15 instances.
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        sw_req_valid [2];
  logic        sw_req_ready [2];
  logic        sw_rsp_valid [2];
  logic        sw_rsp_err   [2];
  logic [31:0] sw_rsp_rdata [2];
  logic        sw_rsp_ready;
  logic [31:0] sw_addr, sw_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc_cyc;
  } req_t;

  req_t        pend[$];
  logic [31:0] mdl_mem [int unsigned];
  bit          busy = 0;
  int          busy_cyc = 0;
  bit          have_exp = 0;
  bit          exp_known;
  logic [31:0] exp_rdata;
  logic        exp_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sw_req_valid[0]), .req_ready(sw_req_ready[0]), .req_we(1'b1),
    .req_addr(sw_addr), .req_wdata(sw_wdata),
    .rsp_valid(sw_rsp_valid[0]), .rsp_ready(sw_rsp_ready),
    .rsp_rdata(sw_rsp_rdata[0]), .rsp_err(sw_rsp_err[0])
  );

  data_mem_responder #(.LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sw_req_valid[1]), .req_ready(sw_req_ready[1]), .req_we(1'b1),
    .req_addr(sw_addr), .req_wdata(sw_wdata),
    .rsp_valid(sw_rsp_valid[1]), .rsp_ready(sw_rsp_ready),
    .rsp_rdata(sw_rsp_rdata[1]), .rsp_err(sw_rsp_err[1])
  );

  task automatic check32(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: the model applies a request when its response appears, so a request
  // discarded by reset never touches the model memory.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      have_exp = 0;
      busy     = 0;
      busy_cyc = 0;
    end else begin
      check32("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      if (have_exp && !rsp_valid) begin
        tests++; fails++;
        $display("FAIL rsp_valid_dropped: got 0, expected 1");
        have_exp = 0;
      end
      if (rsp_valid && !have_exp) begin
        if (pend.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_rsp: rsp_valid=1 with no request outstanding");
        end else begin
          req_t r;
          r = pend.pop_front();
          check32("latency", cyc - r.acc_cyc, LAT + 1);
          exp_known = 1;
          if (r.addr >= 32'd1024) begin
            exp_rdata = 32'd0;
            exp_err   = 1'b1;
          end else if (r.we) begin
            mdl_mem[r.addr] = r.wdata;
            exp_rdata = 32'd0;
            exp_err   = 1'b0;
          end else begin
            exp_err   = 1'b0;
            exp_known = mdl_mem.exists(r.addr);
            exp_rdata = exp_known ? mdl_mem[r.addr] : 32'd0;
          end
          have_exp = 1;
        end
      end
      if (rsp_valid && have_exp) begin
        check32("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        if (exp_known) check32("rsp_rdata", rsp_rdata, exp_rdata);
      end
      if (rsp_valid && rsp_ready) begin
        have_exp = 0;
        busy     = 0;
      end
      if (req_valid && req_ready) begin
        pend.push_back('{we: req_we, addr: req_addr, wdata: req_wdata, acc_cyc: cyc + 1});
        busy = 1;
      end
      busy_cyc = busy ? busy_cyc + 1 : 0;
      if (busy_cyc > 200) begin
        tests++; fails++;
        $display("FAIL busy_timeout: request outstanding for %0d cycles", busy_cyc);
        busy = 0; busy_cyc = 0; have_exp = 0; pend.delete();
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int bp);
    bit seen;
    rsp_ready = (bp == 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: no response for addr 0x%08h", addr);
    end
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, guard, lat;
    bit acc;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    sw_req_valid[0] = 0; sw_req_valid[1] = 0; sw_rsp_ready = 1; sw_addr = 3; sw_wdata = 32'h77;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("rst_rsp_rdata", rsp_rdata, 32'd0);
    check32("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(1, 0, 32'hA5A5A5A5, 0);
    send(1, 5, 32'hDEADBEEF, 0);
    send(0, 5, 0, 0);
    send(0, 5, 0, 6);
    send(1, 1024, 32'h1234, 0);
    send(0, 0, 0, 0);
    send(0, 32'hFFFFFFFF, 0, 0);
    send(1, 7, 32'h11, 0);
    send(0, 5, 0, 0);

    // Store to 7 interrupted by an asynchronous reset while in WAIT.
    req_valid = 1; req_we = 1; req_addr = 7; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check32("async_req_ready", {31'd0, req_ready}, 32'd1);
    check32("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("async_rsp_rdata", rsp_rdata, 32'd0);
    check32("async_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 7, 0, 0);
    check32("mem7_after_reset", mdl_mem[7], 32'h11);

    for (int k = 0; k < 2; k++) begin
      sw_req_valid[k] = 1'b1;
      @(posedge clk); #1;
      sw_req_valid[k] = 1'b0;
      lat = 0;
      for (int t = 0; t < 40; t++) begin
        @(posedge clk); lat++; #1;
        if (sw_rsp_valid[k]) break;
      end
      check32(k == 0 ? "sweep_lat0" : "sweep_lat15", lat, k == 0 ? 1 : 16);
      check32("sweep_err", {31'd0, sw_rsp_err[k]}, 32'd0);
      check32("sweep_rdata", sw_rsp_rdata[k], 32'd0);
      @(posedge clk); #1;
    end

    n = 0; guard = 0;
    req_valid = 1; req_we = $urandom_range(0, 1); req_addr = $urandom_range(0, 15);
    req_wdata = $urandom;
    while (n < 100 && guard < 5000) begin
      guard++;
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      rsp_ready = $urandom_range(0, 1);
      if (acc) begin
        int r;
        n++;
        r = $urandom_range(0, 9);
        req_we    = $urandom_range(0, 1);
        req_wdata = $urandom;
        if (r < 8)       req_addr = $urandom_range(0, 15);
        else if (r == 8) req_addr = 32'd1024 + $urandom_range(0, 100);
        else             req_addr = 32'hFFFF0000 | $urandom;
        if (n == 100) req_valid = 0;
      end
    end
    if (n < 100) begin
      tests++; fails++;
      $display("FAIL b2b_timeout: only %0d of 100 requests accepted", n);
    end
    req_valid = 0;
    rsp_ready = 1;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); guard++;
    end
    repeat (2) @(posedge clk);
    check32("drain_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed 32-bit data-memory responder that serves the load/store requests issued by the processor's MEM stage. It accepts one request at a time over a valid/ready handshake and performs the access after a programmable number of wait states. It returns a response (load data, or store acknowledge) over a second valid/ready handshake. It replaces the in-core data array so the core can act as initiator against a memory with real latency and backpressure.

## Interface
- DEPTH, 1024, number of 32-bit words; valid addresses are 0..DEPTH-1.
- ADDR_W, 10, index width; must equal clog2(DEPTH).
- LATENCY, 2, wait states between accept and access; legal range 0..15.
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  word address (the core's ALU result).
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator takes the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  address ≥ DEPTH.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - capture we, addr, and wdata into holding registers;
  - load cnt=LATENCY (4-bit);
  - go to WAIT.
- WAIT: req_ready=0.
  - If cnt≠0, decrement cnt and stay in WAIT.
  - If cnt==0, perform the access on that edge and go to RESP.
- Access, in range (addr[31:ADDR_W]==0):
  - load: rsp_rdata←mem[addr[ADDR_W-1:0]], rsp_err←0;
  - store: mem[idx]←wdata, rsp_rdata←0, rsp_err←0.
- Access, out of range: no memory write; rsp_rdata←0, rsp_err←1.
- RESP: rsp_valid=1 and req_ready=0. rsp_rdata and rsp_err stay stable until rsp_valid&&rsp_ready; then go to IDLE.
- No new request is accepted in the cycle the response is consumed. The next accept is possible one cycle later, in IDLE.
- Request inputs are sampled only on the accept edge. Later changes to them have no effect.
- Every request, including stores and errors, produces exactly one response. Responses are in order, one outstanding at most.
- Memory array is not reset. Contents are undefined until written.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, cnt=0.
- Reset mid-operation (in WAIT or RESP):
  - the pending request is discarded;
  - a store still in WAIT is never committed;
  - a store already committed, i.e. in RESP, stays in memory.
- Latency: accept at edge E → rsp_valid high after edge E+LATENCY+1.
  - LATENCY=0: response visible one cycle after accept.
  - LATENCY=2 (default): three cycles after accept.
- A store is visible to a subsequent load because the write commits on the edge that enters RESP, before any later accept.
- Throughput with rsp_ready tied high: one request per LATENCY+3 cycles (IDLE accept, LATENCY+1 in WAIT, 1 in RESP).
- rsp_ready is ignored outside RESP. req_valid is ignored outside IDLE.
- Asserting req_valid and rsp_ready together in RESP: the response is consumed and the request is not accepted. The initiator must hold req_valid.

## Test plan
- Store then load: store addr 5, data 0xDEADBEEF → ack with rsp_rdata=0 and rsp_err=0. Load addr 5 → rsp_rdata=0xDEADBEEF, rsp_valid exactly 3 cycles after each accept (LATENCY=2).
- Backpressure: load addr 5 with rsp_ready=0 for 6 cycles. rsp_valid and rsp_rdata=0xDEADBEEF stay stable and req_ready stays 0. Raising rsp_ready for one cycle → rsp_valid=0 next cycle and req_ready=1.
- Out of range: store addr 1024, data 0x1234 → rsp_err=1. Load addr 0 (previously 0xA5A5A5A5) is unchanged. Load addr 0xFFFFFFFF → rsp_err=1, rsp_rdata=0.
- Reset mid-operation:
  - store addr 7, data 0x55 with prior content 0x11;
  - assert rst_n=0 while in WAIT, asynchronously mid-cycle;
  - outputs go to reset values immediately;
  - after release, load addr 7 → 0x11.
- Back-to-back: 100 random load/store requests with req_valid held high and random rsp_ready. Responses are in order and each load matches the scoreboard. A held req_valid is never accepted while in WAIT or RESP.
- Parameter sweep: LATENCY=0 and LATENCY=15. Measured accept-to-rsp_valid is 1 and 16 cycles respectively.
